button_event_decoder: RTL and testbench
=======================================

Name: button_event_decoder

Overview:
- Downstream consumer of the push-button debouncer: takes the stable button level and its one-cycle change strobe and classifies user gestures.
- Gestures are single short press, long press and double click.
- Emits one-cycle event pulses plus an encoded event bus for the LED counter logic (increment/decrement/reset selection).
- All timing is in milliseconds, derived from an internal 1 ms tick prescaler.

Parameters:
- CLK_FREQ_HZ, 10_000_000, system clock in Hz; prescaler terminal count = CLK_FREQ_HZ/1000 - 1; must be >= 1000.
- IS_PULLUP, 0, 1 = released level is 1 (pull-up); 0 = released level is 0 (pull-down).
- LONG_MS, 1000, hold time in ms that qualifies a long press; legal range 1..65535.
- DCLICK_MS, 300, max gap in ms between release and second press for a double click; legal range 1..65535.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_level  input  1  debounced stable button level.
- btn_valid  input  1  one-cycle strobe, high on the cycle btn_level changes.
- short_press  output  1  one-cycle pulse: single short press completed.
- long_press  output  1  one-cycle pulse: hold reached LONG_MS.
- double_click  output  1  one-cycle pulse: second press released.
- event_valid  output  1  OR of the three pulses, same cycle.
- event_code  output  2  00 none, 01 short, 10 long, 11 double; held for one cycle with event_valid, otherwise 00.
- btn_pressed  output  1  registered level, 1 while the button is pressed.

Behaviour:
- Reset: all outputs 0; state IDLE; prescaler 0; ms timer 0. Reset mid-gesture discards the gesture; no event is emitted.
- pressed = btn_level XOR IS_PULLUP[0].
- A press edge is btn_valid && pressed. A release edge is btn_valid && !pressed. When btn_valid is low, btn_level is ignored.
- btn_pressed updates one cycle after a press or release edge.
- Prescaler: counts 0..CLK_FREQ_HZ/1000-1 and asserts ms_tick at the terminal count.
- ms timer: 16-bit, increments on ms_tick, saturates at 0xFFFF.
- On every state transition, both the prescaler and the ms timer clear to 0.
- FSM states and transitions:
  - IDLE: press edge -> PRESS1. Release edge is ignored.
  - PRESS1: release edge -> WAIT2. Else if timer >= LONG_MS -> HOLD, with long_press pulse.
  - HOLD: release edge -> IDLE, no event. Presses are ignored.
  - WAIT2: press edge -> PRESS2. Else if timer >= DCLICK_MS -> IDLE, with short_press pulse.
  - PRESS2: release edge -> IDLE, with double_click pulse. No timeout; long holds in PRESS2 still yield double_click on release.
- Output latency: event pulses are registered and asserted the cycle after the qualifying condition, for exactly 1 cycle.
- Simultaneous events: a button edge wins over a timeout in the same cycle.
  - PRESS1 release at threshold -> WAIT2, no long_press.
  - WAIT2 press at threshold -> PRESS2, no short_press.
- Edges arriving in the cycle after a transition are evaluated normally; there is no dead time.
- Spurious strobe (btn_valid high with a level matching the current state's expectation, e.g. a press edge in PRESS1) causes no state change and no timer clear.
- At most one event pulse per cycle; a minimum of 2 cycles between any two event pulses.

Test Plan:
Bench parameters for all scenarios: CLK_FREQ_HZ=10_000 (10 cycles/ms), LONG_MS=20, DCLICK_MS=5, IS_PULLUP=0.
1. Reset then idle: rst_n low 3 cycles, no strobes for 500 cycles -> all outputs 0, event_code=00 throughout.
2. Short press: press, hold 50 cycles, release, idle -> exactly one short_press and event_code=01, about 50 cycles after the release strobe (+1); no other pulses.
3. Long press: press, hold 300 cycles -> long_press about 200 cycles after the press strobe, event_code=10; the later release produces no event.
4. Double click: press 30 cycles, release, press again 20 cycles later, release after 40 cycles -> one double_click and event_code=11 the cycle after the second release strobe; no short_press.
5. Collision: release strobe on the exact cycle the timer reaches LONG_MS -> no long_press; a short_press follows 50 cycles later. Pull-up variant (IS_PULLUP=1, levels inverted) -> identical event sequence.
6. Reset mid-gesture: press, assert rst_n at cycle 100 of the hold, release after reset -> no pulses; btn_pressed=0; the next clean short press is decoded normally.

Source files
------------

// File: rtl/button_event_if.sv
// Button event bus between the debouncer and the gesture decoder.
// The master side (upstream debouncer) drives the stable level and its change
// strobe. The slave side (the decoder) returns the gesture pulses, the encoded
// event and the registered pressed level.
interface button_event_if;
  logic       btn_level;
  logic       btn_valid;
  logic       short_press;
  logic       long_press;
  logic       double_click;
  logic       event_valid;
  logic [1:0] event_code;
  logic       btn_pressed;

  modport master (
    output btn_level,
    output btn_valid,
    input  short_press,
    input  long_press,
    input  double_click,
    input  event_valid,
    input  event_code,
    input  btn_pressed
  );

  modport slave (
    input  btn_level,
    input  btn_valid,
    output short_press,
    output long_press,
    output double_click,
    output event_valid,
    output event_code,
    output btn_pressed
  );
endinterface

// File: rtl/button_event_decoder.sv
// Button gesture decoder: classifies short press, long press and double click
// from a debounced level plus its change strobe. All timing runs off an
// internal 1 ms tick. Every gesture phase change restarts the ms timebase, so
// the ms timer always measures time spent in the current phase.
module button_event_decoder #(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int IS_PULLUP   = 0,
  parameter int LONG_MS     = 1000,
  parameter int DCLICK_MS   = 300
) (
  input  logic          clk,
  input  logic          rst_n,
  button_event_if.slave bus
);

  localparam int PRESC_MAX = CLK_FREQ_HZ / 1000 - 1;
  localparam int PRESC_W   = (PRESC_MAX < 1) ? 1 : $clog2(PRESC_MAX + 1);

  localparam logic [PRESC_W-1:0] PRESC_TC   = PRESC_W'(PRESC_MAX);
  localparam logic [15:0]        LONG_TC    = 16'(LONG_MS);
  localparam logic [15:0]        DCLICK_TC  = 16'(DCLICK_MS);
  localparam logic [15:0]        MS_SAT     = 16'hFFFF;
  // Level the button shows when released; XOR with it yields "pressed".
  localparam logic               PULLUP_LVL = IS_PULLUP[0];

  localparam logic [1:0] CODE_NONE   = 2'b00;
  localparam logic [1:0] CODE_SHORT  = 2'b01;
  localparam logic [1:0] CODE_LONG   = 2'b10;
  localparam logic [1:0] CODE_DOUBLE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_HOLD   = 3'd2,
    ST_WAIT2  = 3'd3,
    ST_PRESS2 = 3'd4
  } state_t;

  state_t             state_r;
  logic [PRESC_W-1:0] presc_r;
  logic [15:0]        ms_r;
  logic               short_r;
  logic               long_r;
  logic               double_r;
  logic               event_valid_r;
  logic [1:0]         event_code_r;
  logic               pressed_r;

  logic pressed_s;
  logic press_edge_s;
  logic release_edge_s;
  logic ms_tick_s;
  logic long_hit_s;
  logic dclick_hit_s;

  // Decode strobe into press/release edges and evaluate the timing thresholds.
  always_comb begin
    pressed_s      = bus.btn_level ^ PULLUP_LVL;
    press_edge_s   = bus.btn_valid & pressed_s;
    release_edge_s = bus.btn_valid & ~pressed_s;
    ms_tick_s      = (presc_r == PRESC_TC);
    long_hit_s     = (ms_r >= LONG_TC);
    dclick_hit_s   = (ms_r >= DCLICK_TC);
  end

  // Gesture FSM with its timebase and registered event outputs; edges are
  // checked before timeouts so a button edge wins a same-cycle collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      presc_r       <= {PRESC_W{1'b0}};
      ms_r          <= 16'h0000;
      short_r       <= 1'b0;
      long_r        <= 1'b0;
      double_r      <= 1'b0;
      event_valid_r <= 1'b0;
      event_code_r  <= CODE_NONE;
      pressed_r     <= 1'b0;
    end else begin
      // Pulses last one cycle unless re-armed below.
      short_r       <= 1'b0;
      long_r        <= 1'b0;
      double_r      <= 1'b0;
      event_valid_r <= 1'b0;
      event_code_r  <= CODE_NONE;

      if (bus.btn_valid) begin
        pressed_r <= pressed_s;
      end else begin
        pressed_r <= pressed_r;
      end

      // Free-running timebase; a transition below overrides it with a clear.
      if (ms_tick_s) begin
        presc_r <= {PRESC_W{1'b0}};
      end else begin
        presc_r <= presc_r + PRESC_W'(1);
      end
      if (ms_tick_s && (ms_r != MS_SAT)) begin
        ms_r <= ms_r + 16'd1;
      end else begin
        ms_r <= ms_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (press_edge_s) begin
            state_r <= ST_PRESS1;
            presc_r <= {PRESC_W{1'b0}};
            ms_r    <= 16'h0000;
          end
        end
        ST_PRESS1: begin
          if (release_edge_s) begin
            state_r <= ST_WAIT2;
            presc_r <= {PRESC_W{1'b0}};
            ms_r    <= 16'h0000;
          end else if (long_hit_s) begin
            state_r       <= ST_HOLD;
            presc_r       <= {PRESC_W{1'b0}};
            ms_r          <= 16'h0000;
            long_r        <= 1'b1;
            event_valid_r <= 1'b1;
            event_code_r  <= CODE_LONG;
          end
        end
        ST_HOLD: begin
          if (release_edge_s) begin
            state_r <= ST_IDLE;
            presc_r <= {PRESC_W{1'b0}};
            ms_r    <= 16'h0000;
          end
        end
        ST_WAIT2: begin
          if (press_edge_s) begin
            state_r <= ST_PRESS2;
            presc_r <= {PRESC_W{1'b0}};
            ms_r    <= 16'h0000;
          end else if (dclick_hit_s) begin
            state_r       <= ST_IDLE;
            presc_r       <= {PRESC_W{1'b0}};
            ms_r          <= 16'h0000;
            short_r       <= 1'b1;
            event_valid_r <= 1'b1;
            event_code_r  <= CODE_SHORT;
          end
        end
        ST_PRESS2: begin
          // No timeout here: however long the second press, it is a double click.
          if (release_edge_s) begin
            state_r       <= ST_IDLE;
            presc_r       <= {PRESC_W{1'b0}};
            ms_r          <= 16'h0000;
            double_r      <= 1'b1;
            event_valid_r <= 1'b1;
            event_code_r  <= CODE_DOUBLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          presc_r <= {PRESC_W{1'b0}};
          ms_r    <= 16'h0000;
        end
      endcase
    end
  end

  assign bus.short_press  = short_r;
  assign bus.long_press   = long_r;
  assign bus.double_click = double_r;
  assign bus.event_valid  = event_valid_r;
  assign bus.event_code   = event_code_r;
  assign bus.btn_pressed  = pressed_r;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: a pull-down and a pull-up instance receive
// the same gestures (pull-up with inverted level) and both are compared each
// cycle against a gesture model built on elapsed-time arithmetic, plus a
// table of hand-derived checkpoints and a randomized run.
module tb_button_event_decoder;

  localparam int CLK_HZ     = 10_000;
  localparam int LONG_MS    = 20;
  localparam int DCLICK_MS  = 5;
  localparam int CYC_PER_MS = CLK_HZ / 1000;

  logic clk;
  logic rst_n;

  button_event_if bus_pd ();
  button_event_if bus_pu ();

  button_event_decoder #(
    .CLK_FREQ_HZ(CLK_HZ), .IS_PULLUP(0), .LONG_MS(LONG_MS), .DCLICK_MS(DCLICK_MS)
  ) dut_pd (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_pd)
  );

  button_event_decoder #(
    .CLK_FREQ_HZ(CLK_HZ), .IS_PULLUP(1), .LONG_MS(LONG_MS), .DCLICK_MS(DCLICK_MS)
  ) dut_pu (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_pu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Gesture model: phase of the gesture and the edge index at which it began.
  // 0 idle, 1 first press down, 2 held past long, 3 released awaiting 2nd, 4 second down
  int   m_phase;
  int   m_cyc;
  int   m_entry;
  logic m_short, m_long, m_dbl, m_pressed;
  logic cur_prs;

  typedef struct {
    int         wait_cyc;
    logic       prs;
    logic       vld;
    logic [1:0] code;
    logic       bp;
  } vec_t;

  vec_t vecs[$];

  task automatic model_reset();
    m_phase   = 0;
    m_entry   = m_cyc;
    m_short   = 1'b0;
    m_long    = 1'b0;
    m_dbl     = 1'b0;
    m_pressed = 1'b0;
  endtask

  // Advance the model by one clock edge with the inputs sampled at that edge.
  task automatic model_edge(input logic prs, input logic vld);
    int  ms;
    logic pe, re;
    m_cyc++;
    ms = (m_cyc - 1 - m_entry) / CYC_PER_MS;
    if (ms > 65535) ms = 65535;
    pe = vld & prs;
    re = vld & ~prs;
    m_short = 1'b0;
    m_long  = 1'b0;
    m_dbl   = 1'b0;
    if (vld) m_pressed = prs;
    case (m_phase)
      0: if (pe) begin m_phase = 1; m_entry = m_cyc; end
      1: if (re) begin m_phase = 3; m_entry = m_cyc; end
         else if (ms >= LONG_MS) begin m_phase = 2; m_entry = m_cyc; m_long = 1'b1; end
      2: if (re) begin m_phase = 0; m_entry = m_cyc; end
      3: if (pe) begin m_phase = 4; m_entry = m_cyc; end
         else if (ms >= DCLICK_MS) begin m_phase = 0; m_entry = m_cyc; m_short = 1'b1; end
      4: if (re) begin m_phase = 0; m_entry = m_cyc; m_dbl = 1'b1; end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_one(input string nm, input logic sp, input logic lp, input logic dc,
                           input logic ev, input logic [1:0] ec, input logic bp);
    logic [1:0] w_code;
    logic       w_ev;
    w_ev   = m_short | m_long | m_dbl;
    w_code = m_dbl ? 2'b11 : (m_long ? 2'b10 : (m_short ? 2'b01 : 2'b00));
    checks++;
    if ({sp, lp, dc, ev, ec, bp} !== {m_short, m_long, m_dbl, w_ev, w_code, m_pressed}) begin
      failures++;
      $display("FAIL %s cyc=%0d got sp=%b lp=%b dc=%b ev=%b code=%b bp=%b want sp=%b lp=%b dc=%b ev=%b code=%b bp=%b",
               nm, m_cyc, sp, lp, dc, ev, ec, bp, m_short, m_long, m_dbl, w_ev, w_code, m_pressed);
    end
  endtask

  task automatic check_all();
    check_one("model_pd", bus_pd.short_press, bus_pd.long_press, bus_pd.double_click,
              bus_pd.event_valid, bus_pd.event_code, bus_pd.btn_pressed);
    check_one("model_pu", bus_pu.short_press, bus_pu.long_press, bus_pu.double_click,
              bus_pu.event_valid, bus_pu.event_code, bus_pu.btn_pressed);
  endtask

  task automatic step(input logic prs, input logic vld);
    bus_pd.btn_level = prs;
    bus_pd.btn_valid = vld;
    bus_pu.btn_level = ~prs;
    bus_pu.btn_valid = vld;
    @(posedge clk);
    model_edge(prs, vld);
    @(negedge clk);
    check_all();
  endtask

  task automatic reset_cycles(input int n);
    rst_n = 1'b0;
    bus_pd.btn_valid = 1'b0;
    bus_pu.btn_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      model_reset();
      check_all();
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    for (int i = 0; i < v.wait_cyc; i++) step(cur_prs, 1'b0);
    step(v.vld ? v.prs : cur_prs, v.vld);
    if (v.vld) cur_prs = v.prs;
    checks++;
    if (bus_pd.event_code !== v.code || bus_pd.btn_pressed !== v.bp) begin
      failures++;
      $display("FAIL vec%0d got code=%b bp=%b want code=%b bp=%b",
               idx, bus_pd.event_code, bus_pd.btn_pressed, v.code, v.bp);
    end
  endtask

  initial begin
    logic prs_r;
    vec_t v;
    m_cyc   = 0;
    cur_prs = 1'b0;
    rst_n   = 1'b0;
    bus_pd.btn_level = 1'b0;
    bus_pd.btn_valid = 1'b0;
    bus_pu.btn_level = 1'b1;
    bus_pu.btn_valid = 1'b0;
    model_reset();

    // Reset then idle.
    reset_cycles(3);
    vecs.push_back('{500, 1'b0, 1'b0, 2'b00, 1'b0});
    // Short press: hold 50, release, short 51 edges after release.
    vecs.push_back('{0,   1'b1, 1'b1, 2'b00, 1'b1});
    vecs.push_back('{50,  1'b0, 1'b1, 2'b00, 1'b0});
    vecs.push_back('{49,  1'b0, 1'b0, 2'b00, 1'b0});
    vecs.push_back('{0,   1'b0, 1'b0, 2'b01, 1'b0});
    vecs.push_back('{0,   1'b0, 1'b0, 2'b00, 1'b0});
    // Long press: long at 201st edge after press; release gives nothing.
    vecs.push_back('{10,  1'b1, 1'b1, 2'b00, 1'b1});
    vecs.push_back('{199, 1'b1, 1'b0, 2'b00, 1'b1});
    vecs.push_back('{0,   1'b1, 1'b0, 2'b10, 1'b1});
    vecs.push_back('{0,   1'b1, 1'b0, 2'b00, 1'b1});
    vecs.push_back('{98,  1'b0, 1'b1, 2'b00, 1'b0});
    vecs.push_back('{60,  1'b0, 1'b0, 2'b00, 1'b0});
    // Double click.
    vecs.push_back('{5,   1'b1, 1'b1, 2'b00, 1'b1});
    vecs.push_back('{29,  1'b0, 1'b1, 2'b00, 1'b0});
    vecs.push_back('{19,  1'b1, 1'b1, 2'b00, 1'b1});
    vecs.push_back('{39,  1'b0, 1'b1, 2'b11, 1'b0});
    vecs.push_back('{0,   1'b0, 1'b0, 2'b00, 1'b0});
    vecs.push_back('{80,  1'b0, 1'b0, 2'b00, 1'b0});
    // Release on the long threshold cycle: no long, short follows.
    vecs.push_back('{5,   1'b1, 1'b1, 2'b00, 1'b1});
    vecs.push_back('{200, 1'b0, 1'b1, 2'b00, 1'b0});
    vecs.push_back('{49,  1'b0, 1'b0, 2'b00, 1'b0});
    vecs.push_back('{0,   1'b0, 1'b0, 2'b01, 1'b0});
    vecs.push_back('{0,   1'b0, 1'b0, 2'b00, 1'b0});
    // Second press on the double-click threshold: press wins, then double.
    vecs.push_back('{5,   1'b1, 1'b1, 2'b00, 1'b1});
    vecs.push_back('{30,  1'b0, 1'b1, 2'b00, 1'b0});
    vecs.push_back('{50,  1'b1, 1'b1, 2'b00, 1'b1});
    vecs.push_back('{10,  1'b0, 1'b1, 2'b11, 1'b0});
    // Spurious press strobe while pressed does not restart the hold timer.
    vecs.push_back('{5,   1'b1, 1'b1, 2'b00, 1'b1});
    vecs.push_back('{99,  1'b1, 1'b1, 2'b00, 1'b1});
    vecs.push_back('{100, 1'b1, 1'b0, 2'b10, 1'b1});
    vecs.push_back('{5,   1'b0, 1'b1, 2'b00, 1'b0});
    // Release on the cycle right after the press transition.
    vecs.push_back('{3,   1'b1, 1'b1, 2'b00, 1'b1});
    vecs.push_back('{0,   1'b0, 1'b1, 2'b00, 1'b0});
    vecs.push_back('{49,  1'b0, 1'b0, 2'b00, 1'b0});
    vecs.push_back('{0,   1'b0, 1'b0, 2'b01, 1'b0});
    // Release strobe while idle is ignored.
    vecs.push_back('{5,   1'b0, 1'b1, 2'b00, 1'b0});
    vecs.push_back('{60,  1'b0, 1'b0, 2'b00, 1'b0});

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset 100 cycles into a hold, release after reset, then a clean short.
    v = '{5, 1'b1, 1'b1, 2'b00, 1'b1};
    run_vec(v, 100);
    for (int i = 0; i < 99; i++) step(1'b1, 1'b0);
    reset_cycles(3);
    v = '{5, 1'b0, 1'b1, 2'b00, 1'b0};
    run_vec(v, 101);
    v = '{300, 1'b0, 1'b0, 2'b00, 1'b0};
    run_vec(v, 102);
    v = '{5, 1'b1, 1'b1, 2'b00, 1'b1};
    run_vec(v, 103);
    v = '{30, 1'b0, 1'b1, 2'b00, 1'b0};
    run_vec(v, 104);
    v = '{49, 1'b0, 1'b0, 2'b00, 1'b0};
    run_vec(v, 105);
    v = '{0, 1'b0, 1'b0, 2'b01, 1'b0};
    run_vec(v, 106);

    // Randomized gestures, checked cycle by cycle against the model.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        prs_r = 1'($urandom_range(0, 1));
        step(prs_r, 1'b1);
        cur_prs = prs_r;
      end else begin
        step(cur_prs, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
